ss_master: RTL and testbench
============================

SS_MASTER -- requirements
Module: ss_master

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 16, number of save-state slave indices scanned (0..NUM_SLAVES-1).
REQ-002 SHALL have parameter BASE_ADDR, default 0, 64-bit-word base address in external memory for the save image.
REQ-003 SHALL have parameter TIMEOUT, default 255, cycles to wait for any slave acknowledge.
REQ-004 SHALL have port clock  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start_save / start_load  in  1 each  one-cycle start pulses; ignored while busy.
REQ-007 SHALL have port busy / done / error  out  1 each  busy level; done and error one-cycle pulses.
REQ-008 SHALL have port ss_select  out  8  slave index; ss_query, ss_read, ss_write  out  1 each  bus command strobes.
REQ-009 SHALL have port ss_addr  out  24  word address in slave; ss_wdata  out  64  write data.
REQ-010 SHALL have port ss_ack  in  1  slave acknowledge; ss_rdata  in  64  read data, or slave size when answering a query.
REQ-011 SHALL have port mem_req, mem_we  out  1 each; mem_addr  out  32; mem_wdata  out  64; mem_ack  in  1; mem_rdata  in  64.

Function
REQ-012 SHALL implement states IDLE, QUERY, HDR, SS_XFER, MEM_XFER, NEXT, DONE, ERR.
REQ-013 SHALL on a start pulse in IDLE set busy next cycle, clear slave index and word counter, load mem pointer with BASE_ADDR, enter QUERY; start_save wins if both pulse together.
REQ-014 QUERY SHALL hold ss_query with ss_select=index until ss_ack; latched size = ss_rdata[31:0]; size 0 or timeout -> NEXT (slave absent, no header emitted).
REQ-015 HDR (save) SHALL write one header word {index[7:0] in [63:56], size in [31:0], other bits 0} to mem_addr, increment pointer.
REQ-016 HDR (load) SHALL read header word; index or size mismatch -> ERR.
REQ-017 Save loop per word SHALL issue ss_read at ss_addr=counter, latch ss_rdata on ss_ack, then write it to memory, increment counter and pointer.
REQ-018 Load loop per word SHALL read memory at pointer, then issue ss_write with ss_wdata=mem_rdata at ss_addr=counter.
REQ-019 Every strobe and mem_req SHALL stay asserted with address/data stable until its ack, deasserting the cycle after ack is sampled; never more than one outstanding request.
REQ-020 Each ss wait SHALL count cycles; reaching TIMEOUT without ss_ack during read/write -> ERR; timeout counter clears on each new request.
REQ-021 mem waits SHALL have no timeout.
REQ-022 After counter == size, SHALL go to NEXT; NEXT increments index, or -> DONE when index == NUM_SLAVES-1.
REQ-023 DONE SHALL pulse done one cycle, then IDLE with busy low; ERR SHALL pulse error one cycle, drop all strobes, then IDLE.
REQ-024 ss_addr SHALL be counter[23:0]; mem_addr SHALL wrap modulo 2^32.
REQ-025 ss_ack or mem_ack arriving with no request outstanding SHALL be ignored.

Reset
REQ-026 reset_n low SHALL immediately clear all strobes, mem_req, mem_we, busy, done, error, counters, and force IDLE, including mid-transfer; addresses and data outputs reset to 0.
REQ-027 First start SHALL be accepted on the first clock edge after reset_n is released.

Verification
REQ-028 Save, slave 2 size 3 with data A,B,C, others size 0 -> memory at BASE: header {02,3}, A, B, C; done once; 4 mem writes total.
REQ-029 Load of that image -> three ss_write to slave 2 at addr 0,1,2 with A,B,C; done pulse.
REQ-030 Load with header index 3 where slave 2 expected -> error pulse, no ss_write issued.
REQ-031 Slave 5 acks query size 4 then never acks read -> error exactly TIMEOUT cycles after ss_read asserts.
REQ-032 reset_n low during SS_XFER with mem_req high -> all outputs 0 asynchronously; new start_save after release runs full save.
REQ-033 start_save and start_load in same cycle -> save runs; start pulses while busy -> no effect.

Source files
------------

// File: rtl/ss_master.sv
// ss_master - scans save-state slaves and streams their contents to/from an external memory image.
// Rev 1.0
`default_nettype none

module ss_master #(
  parameter int unsigned NUM_SLAVES = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_save,
  input  logic        start_load,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  ss_select,
  output logic        ss_query,
  output logic        ss_read,
  output logic        ss_write,
  output logic [23:0] ss_addr,
  output logic [63:0] ss_wdata,
  input  logic        ss_ack,
  input  logic [63:0] ss_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_QUERY    = 3'd1,
    S_HDR      = 3'd2,
    S_SS_XFER  = 3'd3,
    S_MEM_XFER = 3'd4,
    S_NEXT     = 3'd5,
    S_DONE     = 3'd6,
    S_ERR      = 3'd7
  } state_t;

  localparam logic [7:0]  c_LAST_IDX = 8'(NUM_SLAVES - 1);
  localparam logic [31:0] c_TMO_LAST = 32'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_load;
  logic [7:0]  r_index;
  logic [31:0] r_cnt;
  logic [31:0] r_ptr;
  logic [31:0] r_size;
  logic [63:0] r_data;
  logic [31:0] r_tmo;

  logic [31:0] w_cnt_inc;
  logic        w_cnt_last;
  logic        w_tmo_hit;
  logic        w_hdr_ok;
  logic [63:0] w_hdr;

  assign w_cnt_inc  = r_cnt + 32'd1;
  assign w_cnt_last = (w_cnt_inc == r_size);
  assign w_tmo_hit  = (r_tmo == c_TMO_LAST);
  assign w_hdr      = {r_index, 24'h0, r_size};
  assign w_hdr_ok   = (mem_rdata[63:56] == r_index) && (mem_rdata[31:0] == r_size);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    busy      = (r_state != S_IDLE);
    done      = 1'b0;
    error     = 1'b0;
    ss_select = r_index;
    ss_query  = 1'b0;
    ss_read   = 1'b0;
    ss_write  = 1'b0;
    ss_addr   = r_cnt[23:0];
    ss_wdata  = 64'h0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = r_ptr;
    mem_wdata = 64'h0;

    case (r_state)
      S_IDLE: begin
        if (start_save || start_load) w_next = S_QUERY;
      end
      S_QUERY: begin
        ss_query = 1'b1;
        // An absent slave (size 0 or silent) is skipped without emitting a header.
        if (ss_ack)         w_next = (ss_rdata[31:0] == 32'h0) ? S_NEXT : S_HDR;
        else if (w_tmo_hit) w_next = S_NEXT;
      end
      S_HDR: begin
        mem_req   = 1'b1;
        mem_we    = !r_load;
        mem_wdata = r_load ? 64'h0 : w_hdr;
        if (mem_ack) begin
          if (!r_load)       w_next = S_SS_XFER;
          else if (w_hdr_ok) w_next = S_MEM_XFER;
          else               w_next = S_ERR;
        end
      end
      S_SS_XFER: begin
        ss_read  = !r_load;
        ss_write = r_load;
        ss_wdata = r_load ? r_data : 64'h0;
        if (ss_ack)         w_next = (r_load && w_cnt_last) ? S_NEXT : (r_load ? S_MEM_XFER : S_MEM_XFER);
        else if (w_tmo_hit) w_next = S_ERR;
      end
      S_MEM_XFER: begin
        mem_req   = 1'b1;
        mem_we    = !r_load;
        mem_wdata = r_load ? 64'h0 : r_data;
        if (mem_ack) w_next = (!r_load && w_cnt_last) ? S_NEXT : S_SS_XFER;
      end
      S_NEXT: begin
        w_next = (r_index == c_LAST_IDX) ? S_DONE : S_QUERY;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        error  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_load  <= 1'b0;
      r_index <= 8'h0;
      r_cnt   <= 32'h0;
      r_ptr   <= 32'h0;
      r_size  <= 32'h0;
      r_data  <= 64'h0;
      r_tmo   <= 32'h0;
    end else begin
      // The wait timer restarts whenever a new slave request begins.
      r_tmo <= ((r_state == S_QUERY || r_state == S_SS_XFER) && (w_next == r_state)) ?
               r_tmo + 32'd1 : 32'h0;
      case (r_state)
        S_IDLE: begin
          if (start_save || start_load) begin
            r_load  <= !start_save;
            r_index <= 8'h0;
            r_cnt   <= 32'h0;
            r_ptr   <= BASE_ADDR;
          end
        end
        S_QUERY: begin
          if (ss_ack) r_size <= ss_rdata[31:0];
        end
        S_HDR: begin
          if (mem_ack) r_ptr <= r_ptr + 32'd1;
        end
        S_SS_XFER: begin
          if (ss_ack) begin
            if (r_load) r_cnt  <= w_cnt_inc;
            else        r_data <= ss_rdata;
          end
        end
        S_MEM_XFER: begin
          if (mem_ack) begin
            r_ptr <= r_ptr + 32'd1;
            if (r_load) r_data <= mem_rdata;
            else        r_cnt  <= w_cnt_inc;
          end
        end
        S_NEXT: begin
          r_cnt <= 32'h0;
          if (r_index != c_LAST_IDX) r_index <= r_index + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ss_master.sv
// tb_ss_master - directed bench for ss_master with behavioural slave and memory responders.
// Rev 1.0
`default_nettype none

module tb_ss_master;

  localparam int unsigned NS      = 8;
  localparam logic [31:0] TB_BASE = 32'h0000_0100;
  localparam int unsigned TMO     = 20;
  localparam logic [63:0] C_DAT [0:2] = '{64'hAAAA_0000_1111_0001,
                                          64'hBBBB_0000_2222_0002,
                                          64'hCCCC_0000_3333_0003};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_save = 1'b0;
  logic        start_load = 1'b0;
  logic        busy, done, error;
  logic [7:0]  ss_select;
  logic        ss_query, ss_read, ss_write;
  logic [23:0] ss_addr;
  logic [63:0] ss_wdata;
  logic        ss_ack = 1'b0;
  logic [63:0] ss_rdata = 64'h0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = 64'h0;

  ss_master #(.NUM_SLAVES(NS), .BASE_ADDR(TB_BASE), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .start_save(start_save), .start_load(start_load),
    .busy(busy), .done(done), .error(error),
    .ss_select(ss_select), .ss_query(ss_query), .ss_read(ss_read), .ss_write(ss_write),
    .ss_addr(ss_addr), .ss_wdata(ss_wdata), .ss_ack(ss_ack), .ss_rdata(ss_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Stimulus-controlled environment knobs.
  logic [31:0] sz     [0:NS-1];
  logic        noack  [0:NS-1];
  int          mem_lat = 0;
  logic        hdr_override = 1'b0;

  logic [63:0] mem [0:15];
  logic [31:0] moff;
  int          mcnt = 0;
  int          n_mw = 0;
  int          cyc = 0;
  assign moff = mem_addr - TB_BASE;

  logic [7:0]  wsel  [0:15];
  logic [23:0] waddr [0:15];
  logic [63:0] wdat  [0:15];
  int          n_ssw = 0;

  int   n_done = 0, n_err = 0, t_read = 0, t_err = 0;
  logic prev_read = 1'b0;
  int   n_chk = 0, n_fail = 0;

  function automatic logic [63:0] sdata(input logic [7:0] sel, input logic [23:0] a);
    if (sel == 8'd2 && a < 24'd3) return C_DAT[a];
    return {sel, 32'hBAD0_0000, a};
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    ss_ack <= 1'b0;
    if ((ss_query || ss_read || ss_write) && !ss_ack) begin
      if (ss_query) begin
        ss_ack   <= 1'b1;
        ss_rdata <= {32'hFFFF_0000, sz[ss_select[2:0]]};
      end else if (ss_read && !noack[ss_select[2:0]]) begin
        ss_ack   <= 1'b1;
        ss_rdata <= sdata(ss_select, ss_addr);
      end else if (ss_write) begin
        ss_ack <= 1'b1;
        if (n_ssw < 16) begin
          wsel[n_ssw]  <= ss_select;
          waddr[n_ssw] <= ss_addr;
          wdat[n_ssw]  <= ss_wdata;
        end
        n_ssw <= n_ssw + 1;
      end
    end
  end

  always @(posedge clock) begin
    mem_ack <= 1'b0;
    if (mem_req && !mem_ack) begin
      if (mcnt >= mem_lat) begin
        mcnt    <= 0;
        mem_ack <= 1'b1;
        if (mem_we) begin
          mem[moff[3:0]] <= mem_wdata;
          n_mw <= n_mw + 1;
        end else begin
          mem_rdata <= (hdr_override && moff == 32'h0) ? 64'h0300_0000_0000_0003 : mem[moff[3:0]];
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  always @(negedge clock) begin
    if (done)  n_done <= n_done + 1;
    if (error) begin
      n_err <= n_err + 1;
      t_err <= cyc;
    end
    if (ss_read && !prev_read) t_read <= cyc;
    prev_read <= ss_read;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller sits at a negedge; the pulse spans exactly one rising edge.
  task automatic pulse(input logic s, input logic l);
    start_save = s;
    start_load = l;
    @(negedge clock);
    start_save = 1'b0;
    start_load = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clock);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic ok;
    int   d0, e0, w0, s0;

    for (int i = 0; i < NS; i++) begin
      sz[i]    = 32'h0;
      noack[i] = 1'b0;
    end
    sz[2] = 32'd3;

    repeat (3) @(negedge clock);
    chk("rst_ctrl", {busy, done, error, ss_query, ss_read, ss_write, mem_req, mem_we}, 8'h00);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_ss_addr", ss_addr, 24'h0);

    // Save: both starts together, released with reset, then stray starts while busy.
    d0 = n_done; e0 = n_err; w0 = n_mw; s0 = n_ssw;
    reset_n = 1'b1;
    pulse(1'b1, 1'b1);
    chk("save_busy", busy, 1'b1);
    repeat (3) begin
      pulse(1'b0, 1'b1);
      @(negedge clock);
    end
    wait_idle(1000, ok);
    chk("save_finish", ok, 1'b1);
    repeat (2) @(negedge clock);
    chk("save_hdr", mem[0], 64'h0200_0000_0000_0003);
    chk("save_A", mem[1], C_DAT[0]);
    chk("save_B", mem[2], C_DAT[1]);
    chk("save_C", mem[3], C_DAT[2]);
    chk("save_nwrites", n_mw - w0, 4);
    chk("save_done", n_done - d0, 1);
    chk("save_err", n_err - e0, 0);
    chk("save_no_sswrite", n_ssw - s0, 0);

    // Load the image back into slave 2.
    d0 = n_done; e0 = n_err; w0 = n_mw; s0 = n_ssw;
    pulse(1'b0, 1'b1);
    wait_idle(1000, ok);
    chk("load_finish", ok, 1'b1);
    repeat (2) @(negedge clock);
    chk("load_nwrites", n_ssw - s0, 3);
    for (int i = 0; i < 3; i++) begin
      chk("load_sel", wsel[s0 + i], 8'd2);
      chk("load_addr", waddr[s0 + i], 24'(i));
      chk("load_data", wdat[s0 + i], C_DAT[i]);
    end
    chk("load_done", n_done - d0, 1);
    chk("load_err", n_err - e0, 0);
    chk("load_no_memwrite", n_mw - w0, 0);

    // Load with a header claiming slave 3 where slave 2 is expected.
    d0 = n_done; e0 = n_err; s0 = n_ssw;
    hdr_override = 1'b1;
    pulse(1'b0, 1'b1);
    wait_idle(1000, ok);
    chk("mism_finish", ok, 1'b1);
    repeat (2) @(negedge clock);
    hdr_override = 1'b0;
    chk("mism_err", n_err - e0, 1);
    chk("mism_done", n_done - d0, 0);
    chk("mism_no_sswrite", n_ssw - s0, 0);

    // Slave 5 reports size 4 but never answers the read.
    sz[2] = 32'h0; sz[5] = 32'd4; noack[5] = 1'b1;
    d0 = n_done; e0 = n_err;
    pulse(1'b1, 1'b0);
    wait_idle(1000, ok);
    chk("tmo_finish", ok, 1'b1);
    repeat (2) @(negedge clock);
    chk("tmo_err", n_err - e0, 1);
    chk("tmo_done", n_done - d0, 0);
    chk("tmo_cycles", t_err - t_read, TMO);
    chk("tmo_hdr", mem[0], 64'h0500_0000_0000_0004);
    chk("tmo_idle_strobes", {ss_read, mem_req, busy}, 3'b000);

    // Reset in the middle of a save while a memory write is pending.
    sz[5] = 32'h0; noack[5] = 1'b0; sz[2] = 32'd3; mem_lat = 5;
    pulse(1'b1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (mem_req && mem_we && mem_addr == TB_BASE + 32'd1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rstmid_reached", ok, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_ctrl", {busy, done, error, ss_query, ss_read, ss_write, mem_req, mem_we}, 8'h00);
    chk("rstmid_sel", ss_select, 8'h0);
    chk("rstmid_mem_addr", mem_addr, 32'h0);
    chk("rstmid_wdata", mem_wdata, 64'h0);
    repeat (2) @(negedge clock);
    d0 = n_done; w0 = n_mw;
    reset_n = 1'b1;
    pulse(1'b1, 1'b0);
    chk("rstmid_restart_busy", busy, 1'b1);
    wait_idle(2000, ok);
    chk("rstmid_finish", ok, 1'b1);
    repeat (2) @(negedge clock);
    chk("rstmid_hdr", mem[0], 64'h0200_0000_0000_0003);
    chk("rstmid_C", mem[3], C_DAT[2]);
    chk("rstmid_nwrites", n_mw - w0, 4);
    chk("rstmid_done", n_done - d0, 1);

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
